// File: rtl/grb_pkg.sv
// Shared definitions for the addressable-LED output chain: encoder modes and
// the frame sequencer state encoding.
package grb_pkg;

  localparam logic [1:0] QM_ZERO = 2'b00;
  localparam logic [1:0] QM_ONE  = 2'b01;
  localparam logic [1:0] QM_LOW  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIP  = 2'd1,
    LATCH = 2'd2
  } grb_seq_state_t;

endpackage

// File: rtl/grb_latch_timer.sv
// One-shot interval timer: start arms it, expired pulses for one cycle on the
// CYCLES-th cycle after start. Also used for the power-on blanking interval.
module grb_latch_timer #(
  parameter int CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          running_reg;

  assign expired = running_reg && (cnt_reg == LAST);

  // start wins over clear so a restart in the same cycle is never lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      cnt_reg     <= '0;
      running_reg <= 1'b1;
    end else if (clear || expired) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (running_reg) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/grb_frame_sequencer.sv
// Frame sequencer: walks num_leds pixel words bit by bit into the bit encoder,
// then holds the line low for the latch interval before pulsing done.
module grb_frame_sequencer
  import grb_pkg::*;
#(
  parameter  int BITS_PER_LED = 24,
  parameter  int MAX_LEDS     = 8,
  parameter  int LATCH_CYCLES = 5000,
  localparam int LEDW         = $clog2(MAX_LEDS + 1),
  localparam int IDXW         = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ship,
  input  logic [LEDW-1:0] num_leds,
  input  logic            theBit,
  input  logic            bdone,
  output logic [1:0]      qmode,
  output logic            load_pattern,
  output logic [IDXW-1:0] led_index,
  output logic            shift_pattern,
  output logic            start_coding,
  output logic            busy,
  output logic            done
);

  localparam int BCW = $clog2(BITS_PER_LED);
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(BITS_PER_LED - 1);
  localparam logic [LEDW-1:0] MAX_N    = LEDW'(MAX_LEDS);

  grb_seq_state_t  state_reg, state_next;
  logic [BCW-1:0]  bit_cnt_reg;
  logic [IDXW-1:0] led_cnt_reg;
  logic [LEDW-1:0] n_q_reg;

  logic accept, bit_last, led_last, frame_end, latch_expired;

  assign accept    = (state_reg == IDLE) && ship && (num_leds != '0);
  assign bit_last  = (bit_cnt_reg == BIT_LAST);
  assign led_last  = (LEDW'(led_cnt_reg) + LEDW'(1)) >= n_q_reg;
  assign frame_end = (state_reg == SHIP) && bdone && bit_last && led_last;

  grb_latch_timer #(
    .CYCLES (LATCH_CYCLES)
  ) u_latch_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (frame_end),
    .clear   (state_reg == IDLE),
    .expired (latch_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)        state_next = SHIP;
      SHIP:    if (frame_end)     state_next = LATCH;
      LATCH:   if (latch_expired) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // n_q is latched once per frame so later num_leds changes cannot disturb it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg <= '0;
      led_cnt_reg <= '0;
      n_q_reg     <= '0;
    end else if (accept) begin
      bit_cnt_reg <= '0;
      led_cnt_reg <= '0;
      n_q_reg     <= (num_leds > MAX_N) ? MAX_N : num_leds;
    end else if ((state_reg == SHIP) && bdone) begin
      if (!bit_last) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end else if (!led_last) begin
        led_cnt_reg <= led_cnt_reg + 1'b1;
        bit_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    qmode         = QM_LOW;
    load_pattern  = 1'b0;
    shift_pattern = 1'b0;
    start_coding  = 1'b0;
    led_index     = '0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          load_pattern = 1'b1;
          start_coding = 1'b1;
        end
      end
      SHIP: begin
        qmode     = {1'b0, theBit};
        led_index = led_cnt_reg;
        if (bdone) begin
          if (!bit_last) begin
            shift_pattern = 1'b1;
          end else if (!led_last) begin
            load_pattern = 1'b1;
            led_index    = led_cnt_reg + 1'b1;
          end
        end
      end
      LATCH: begin
        led_index = led_cnt_reg;
        done      = latch_expired;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/grb_frame_sequencer.md
# grb_frame_sequencer

Parametrised frame sequencer for the addressable-LED output chain. It walks a frame of `num_leds` pixel words of `BITS_PER_LED` bits each. It requests each pixel word from the pattern source and steps the shift register bit by bit, feeding the bit encoder through `qmode`. Each frame ends with a counted latch (line-low) interval before `done`. It sits between the frame-request logic and the bit encoder, and supports GRB (24-bit) and GRBW (32-bit) strips with a runtime LED count.

## Interface
- `BITS_PER_LED`, 24, bits per pixel word (24 = GRB, 32 = GRBW); must be ≥ 2.
- `MAX_LEDS`, 8, largest LED count per frame.
- `LATCH_CYCLES`, 5000, clk cycles of line-low after the last bit; must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ship`  in  1  start-frame pulse; honoured only when idle.
- `num_leds`  in  LEDW=$clog2(MAX_LEDS+1)  LED count, sampled on an accepted `ship`.
- `theBit`  in  1  current MSB of the pixel shift register.
- `bdone`  in  1  one-cycle pulse from the bit encoder: current bit finished.
- `qmode`  out  2  encoder mode: 2'b00 = send 0, 2'b01 = send 1, 2'b10 = hold line low.
- `load_pattern`  out  1  load the next pixel word into the shift register.
- `led_index`  out  IDXW=$clog2(MAX_LEDS)  index of the pixel word being requested or shipped.
- `shift_pattern`  out  1  shift the pattern register by one bit.
- `start_coding`  out  1  start the bit encoder (first bit of frame).
- `busy`  out  1  high from an accepted `ship` until `done`.
- `done`  out  1  one-cycle pulse at the end of the latch interval.

## Operation
- States: IDLE, SHIP, LATCH.
- **IDLE**
  - `qmode` = 2'b10; `busy` = 0.
  - `ship` with `num_leds` ≠ 0 is accepted:
    - `n_q` <= min(`num_leds`, MAX_LEDS); `led_cnt` <= 0; `bit_cnt` <= 0.
    - `load_pattern` and `start_coding` are asserted in the same cycle (Mealy), with `led_index` = 0.
    - Next state: SHIP.
  - `ship` with `num_leds` = 0 is ignored: no outputs, no `done`.
- **SHIP**
  - `qmode` = {1'b0, `theBit`}.
  - On `bdone`:
    - If `bit_cnt` < BITS_PER_LED-1: `shift_pattern` = 1; `bit_cnt`++.
    - Else, if `led_cnt` < `n_q`-1: `load_pattern` = 1 with `led_index` = `led_cnt`+1 in that cycle; `led_cnt`++; `bit_cnt` <= 0.
    - Else (last bit of last LED): `latch_cnt` <= 0; next state LATCH.
  - No `bdone`: hold.
- **LATCH**
  - `qmode` = 2'b10; `latch_cnt` increments each cycle.
  - When `latch_cnt` = LATCH_CYCLES-1: `done` = 1 for one cycle; next state IDLE.
- `ship` in SHIP or LATCH is ignored. `num_leds` changes after acceptance have no effect on the current frame.
- `shift_pattern` and `load_pattern` are never asserted in the same cycle.
- `led_index` = `led_cnt` except in the two `load_pattern` cycles defined above. It is 0 in IDLE.
- Counter widths:
  - `bit_cnt`: $clog2(BITS_PER_LED).
  - `led_cnt`: IDXW.
  - `latch_cnt`: $clog2(LATCH_CYCLES+1).
  - No counter ever wraps; the terminal compare always fires first.
- **Reset**, asynchronous, at any time including mid-frame:
  - State returns to IDLE and all counters clear.
  - Outputs at reset: `qmode` = 2'b10; `busy` = 0; `done` = 0; `led_index` = 0; `load_pattern`, `shift_pattern`, `start_coding` = 0.
  - No `done` is produced for an aborted frame.

## Timing
- Accepted `ship` → `load_pattern`/`start_coding` in the same cycle; `busy` = 1 from the next edge.
- Per frame:
  - `load_pattern` pulses: `n_q`.
  - `shift_pattern` pulses: `n_q`·(BITS_PER_LED-1).
  - `bdone` pulses consumed: `n_q`·BITS_PER_LED.
- Final `bdone` edge → LATCH. `done` is asserted LATCH_CYCLES cycles after entering LATCH. `busy` falls on the edge after `done`.
- Earliest re-accepted `ship` is the cycle after `done`: back-to-back frames, no extra gap.
- `bdone` arriving in IDLE or LATCH is ignored.

## Structure
- Shared package `grb_pkg`:
  - qmode constants QM_ZERO = 2'b00, QM_ONE = 2'b01, QM_LOW = 2'b10.
  - State enum `grb_seq_state_t` {IDLE, SHIP, LATCH}.
- One sub-module, `grb_latch_timer`: start/clear, counts to LATCH_CYCLES, one-cycle `expired` output. It is reused later for the power-on blanking interval.
- Bit/LED counters and the FSM stay in `grb_frame_sequencer`.

## Test plan
Unless stated, BITS_PER_LED = 24, MAX_LEDS = 8, LATCH_CYCLES = 16; encoder model returns `bdone` every 4 cycles.
- **Single LED.** `ship` with `num_leds` = 1, pattern 0xA5F00F.
  - 1 `load_pattern` (`led_index` 0), 23 `shift_pattern`.
  - `qmode` follows bits 1,0,1,0,0,1,0,1,…
  - Then `qmode` = 2'b10 for 16 cycles; `done` on the 16th; `busy` drops next edge.
- **Three LEDs.** `num_leds` = 3.
  - `load_pattern` ×3 with `led_index` 0, 1, 2; 69 `shift_pattern`; 72 `bdone` consumed; exactly one `done`.
- **Count edges.**
  - `num_leds` = 0 → no activity, `busy` stays 0.
  - `num_leds` = 12 → saturates to 8: 192 bits, 8 loads.
- **Ignored inputs.**
  - `ship` pulses mid-SHIP and mid-LATCH, and `num_leds` changed 3→5 mid-frame → frame still 72 bits, single `done`.
  - Stray `bdone` in LATCH leaves the latch count unaffected.
- **Reset mid-frame.** `reset` after 30 bits.
  - Same cycle: `qmode` = 2'b10, `busy` = 0, no `done`.
  - A new `ship` (`num_leds` = 2) restarts at `led_index` 0 and yields 48 bits.
- **GRBW and back-to-back.** BITS_PER_LED = 32, `num_leds` = 2.
  - 62 `shift_pattern`, 2 loads.
  - `ship` in the cycle after `done` is accepted immediately.
